bloco_operativo: RTL
====================

BLOCO_OPERATIVO -- requirements
Module: bloco_operativo

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 The block SHALL provide the following data and control ports:
- X_in  input  8  unsigned operand, sampled only when LX=1.
- LX  input  1  load enable for RX.
- LS  input  1  load enable for RS.
- LH  input  1  load enable for RH.
- H  input  1  ALU operation select: 1=add, 0=multiply.
- M0  input  2  operand-A select.
- M1  input  2  operand-B select.
- M2  input  2  write-data select for RS/RH.
- S  output  16  current RS contents.
- T  output  16  current RH contents.
- Z  output  1  registered zero flag.
- OVF  output  1  sticky overflow flag.

Function
REQ-003 The block SHALL hold three 16-bit registers: RX, RS and RH; S=RS and T=RH combinationally.
REQ-004 Operand A SHALL be selected by M0: 0=RX, 1=RS, 2=RH, 3=16'h0001.
REQ-005 Operand B SHALL be selected by M1: 0=RS, 1=RH, 2=RX, 3=16'h0000.
REQ-006 The ALU SHALL compute a 17-bit sum when H=1, or a 32-bit product when H=0.
REQ-007 An ALU overflow SHALL be flagged when the sum bit 16 is 1 or product bits 31:16 are non-zero; the 16-bit result is wrapped or saturated per REQ-017.
REQ-008 Write data SHALL be selected by M2: 0=ALU result, 1={8'h00,X_in}, 2=ALU result >>1 (logical), 3=16'h0000.
REQ-009 On a clk edge with LX=1, RX SHALL load {8'h00,X_in}; with LS=1, RS SHALL load the write data; with LH=1, RH SHALL load the write data.
REQ-010 All operand reads SHALL use pre-edge register values: when LX, LS and LH are asserted together, every load uses the old RX/RS/RH, and RS and RH receive identical write data.
REQ-011 A register whose load enable is 0 SHALL hold its value; with all enables 0 the block SHALL be fully static.
REQ-012 Z SHALL update only on edges with LS=1, to 1 if the value loaded into RS is 16'h0000 and to 0 otherwise; Z otherwise holds.
REQ-013 OVF SHALL set on any edge where (LS or LH)=1, M2 is 0 or 2, and an ALU overflow occurred.
REQ-014 OVF SHALL then hold until reset, or until an LX=1 edge with no simultaneous overflow; a simultaneous overflow takes priority and sets OVF.
REQ-015 Load latency SHALL be one cycle: a value loaded on edge n is visible on S/T/Z/OVF after edge n.

Reset
REQ-016 With reset=1 at a clk edge, RX, RS and RH SHALL become 16'h0000 and Z=1, OVF=0, overriding all load enables; reset asserted mid-sequence SHALL discard all in-flight loads.

Configuration
REQ-017 Saturating arithmetic SHALL be controlled by macro BLOCO_OPERATIVO_SAT_EN:
- When defined, an overflowing ALU result SHALL be replaced by 16'hFFFF before the M2 mux; in that case M2=2 yields 16'h7FFF.
- When undefined, the low 16 bits SHALL be used (wrap-around).
- OVF behaviour SHALL be identical in both builds.

Verification
REQ-018 The bench SHALL cover reset: assert reset with LX=LS=LH=1 and X_in=8'hAA -> after the edge RX=RS=RH=0, Z=1, OVF=0.
REQ-019 The bench SHALL cover multiply then add:
- LX=1, X_in=5 -> RX=5.
- Then M0=0, M1=2, H=0, M2=0, LS=1 -> S=25, Z=0.
- Then M0=1, M1=2, H=1, M2=0, LH=1 -> T=30.
REQ-020 The bench SHALL cover overflow:
- LX=1, X_in=255, then RX*RX into RS -> S=16'hFE01, OVF=0.
- Then M0=1, M1=0, H=1, M2=0, LS=1 -> S=16'hFC02 (no SAT) or 16'hFFFF (SAT), OVF=1.
- Then LX=1 with LS=LH=0 -> OVF=0.
REQ-021 The bench SHALL cover simultaneous loads:
- RS=25, RH=30, M0=1, M1=1, H=1, M2=2, LS=LH=1 -> S=T=27.
- Next edge, same controls -> S=T=27.
REQ-022 The bench SHALL cover clear and zero flag: M2=3, LS=1 -> S=0, Z=1; following edge with all enables 0 -> S, T, Z, OVF unchanged.

Source files
------------

// File: rtl/bloco_operativo.sv
// bloco_operativo: RX/RS/RH datapath with an add/multiply ALU, registered zero flag and sticky overflow.
// Optional feature: define BLOCO_OPERATIVO_SAT_EN to saturate overflowing ALU results to 16'hFFFF.
module bloco_operativo (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  X_in,
    input  logic        LX,
    input  logic        LS,
    input  logic        LH,
    input  logic        H,
    input  logic [1:0]  M0,
    input  logic [1:0]  M1,
    input  logic [1:0]  M2,
    output logic [15:0] S,
    output logic [15:0] T,
    output logic        Z,
    output logic        OVF
);

    logic [15:0] rx, rs, rh;
    logic [15:0] op_a, op_b;
    logic [16:0] sum;
    logic [31:0] prod;
    logic        alu_ovf;
    logic [15:0] alu_raw, alu_res, wdata;
    logic        ovf_set;

    assign S = rs;
    assign T = rh;

    always_comb begin
        op_a = 16'h0000;
        case (M0)
            2'd0:    op_a = rx;
            2'd1:    op_a = rs;
            2'd2:    op_a = rh;
            default: op_a = 16'h0001;
        endcase
    end

    always_comb begin
        op_b = 16'h0000;
        case (M1)
            2'd0:    op_b = rs;
            2'd1:    op_b = rh;
            2'd2:    op_b = rx;
            default: op_b = 16'h0000;
        endcase
    end

    assign sum     = {1'b0, op_a} + {1'b0, op_b};
    assign prod    = {16'h0000, op_a} * {16'h0000, op_b};
    assign alu_ovf = H ? sum[16] : (prod[31:16] != 16'h0000);
    assign alu_raw = H ? sum[15:0] : prod[15:0];

`ifdef BLOCO_OPERATIVO_SAT_EN
    assign alu_res = alu_ovf ? 16'hFFFF : alu_raw;
`else
    assign alu_res = alu_raw;
`endif

    always_comb begin
        wdata = 16'h0000;
        case (M2)
            2'd0:    wdata = alu_res;
            2'd1:    wdata = {8'h00, X_in};
            2'd2:    wdata = {1'b0, alu_res[15:1]};
            default: wdata = 16'h0000;
        endcase
    end

    // Overflow only counts when an ALU-derived value is actually written somewhere.
    assign ovf_set = (LS | LH) && ((M2 == 2'd0) || (M2 == 2'd2)) && alu_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx  <= 16'h0000;
            rs  <= 16'h0000;
            rh  <= 16'h0000;
            Z   <= 1'b1;
            OVF <= 1'b0;
        end else begin
            if (LX) rx <= {8'h00, X_in};
            if (LS) begin
                rs <= wdata;
                Z  <= (wdata == 16'h0000);
            end
            if (LH) rh <= wdata;
            // A new overflow wins over the LX-driven clear.
            if (ovf_set)  OVF <= 1'b1;
            else if (LX)  OVF <= 1'b0;
        end
    end

endmodule
